// File: rtl/ext_stream_unit_if.sv
// rtl/ext_stream_unit_if.sv - input/output stream bundle for ext_stream_unit
interface ext_stream_unit_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [2:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;
    logic             err_sticky;

    modport slave (
        input  in_valid, in_data, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_illegal, err_sticky
    );

    modport master (
        output in_valid, in_data, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_illegal, err_sticky
    );
endinterface

// File: rtl/ext_stream_unit.sv
// rtl/ext_stream_unit.sv - pipelined immediate extender with 2-entry skid buffer
module ext_stream_unit #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    ext_stream_unit_if.slave s
);
    localparam int XW = OUT_W + 2;
    localparam int HW = IN_W / 2;

    logic [IN_W-1:0]  d;
    logic [OUT_W-1:0] ext_data;
    logic             ext_ill;

    assign d = s.in_data;

    // Arithmetic is done OUT_W+2 wide so the branch shift cannot lose sign before truncation.
    always_comb begin
        ext_data = '0;
        ext_ill  = 1'b0;
        case (s.in_mode)
            3'b000:  ext_data = OUT_W'(XW'(d));
            3'b001:  ext_data = OUT_W'(XW'($signed(d)));
            3'b010:  ext_data = OUT_W'(XW'(d) << (OUT_W - IN_W));
            3'b011:  ext_data = OUT_W'(XW'($signed(d)) << 2);
            3'b100:  ext_data = OUT_W'(XW'($signed(d[7:0])));
            3'b101:  ext_data = OUT_W'(XW'(d[7:0]));
            3'b110:  ext_data = OUT_W'(XW'($signed(d[HW-1:0])));
            default: ext_ill  = 1'b1;
        endcase
    end

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_ill_q, out_ill_d;
    logic             skid_valid_q, skid_valid_d;
    logic [OUT_W-1:0] skid_data_q, skid_data_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             skid_ill_q, skid_ill_d;
    logic             err_q, err_d;

    logic in_fire;
    logic out_free;

    // in_ready comes straight from a flop, so upstream never sees out_ready combinationally.
    assign in_fire  = s.in_valid && !skid_valid_q;
    assign out_free = !out_valid_q || s.out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_tag_d    = out_tag_q;
        out_ill_d    = out_ill_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_tag_d   = skid_tag_q;
        skid_ill_d   = skid_ill_q;
        err_d        = err_q || (in_fire && ext_ill);

        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_tag_d    = skid_tag_q;
                out_ill_d    = skid_ill_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_valid_d = 1'b1;
                out_data_d  = ext_data;
                out_tag_d   = s.in_tag;
                out_ill_d   = ext_ill;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = ext_data;
            skid_tag_d   = s.in_tag;
            skid_ill_d   = ext_ill;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_tag_q    <= '0;
            out_ill_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_tag_q   <= '0;
            skid_ill_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_tag_q    <= out_tag_d;
            out_ill_q    <= out_ill_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_tag_q   <= skid_tag_d;
            skid_ill_q   <= skid_ill_d;
            err_q        <= err_d;
        end
    end

    assign s.in_ready    = !skid_valid_q;
    assign s.out_valid   = out_valid_q;
    assign s.out_data    = out_data_q;
    assign s.out_tag     = out_tag_q;
    assign s.out_illegal = out_ill_q;
    assign s.err_sticky  = err_q;
endmodule

// File: tb/tb_ext_stream_unit.sv
// tb/tb_ext_stream_unit.sv - scoreboard bench for ext_stream_unit (16->32 and 8->16)
module tb_ext_stream_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    ext_stream_unit_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) ia ();
    ext_stream_unit_if #(.IN_W(8),  .OUT_W(16), .TAG_W(5)) ib ();

    ext_stream_unit #(.IN_W(16), .OUT_W(32), .TAG_W(5)) u_a (.clk(clk), .reset_n(reset_n), .s(ia));
    ext_stream_unit #(.IN_W(8),  .OUT_W(16), .TAG_W(5)) u_b (.clk(clk), .reset_n(reset_n), .s(ib));

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        ill;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_acc = -1;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && ia.out_valid && ia.out_ready) begin
            if (sb_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected: got beat tag %h with empty scoreboard", ia.out_tag);
            end else begin
                exp_t e;
                e = sb_a.pop_front();
                chk("a_data", ia.out_data, e.data);
                chk("a_tag", 32'(ia.out_tag), 32'(e.tag));
                chk("a_illegal", 32'(ia.out_illegal), 32'(e.ill));
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && ib.out_valid && ib.out_ready) begin
            if (sb_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected: got beat tag %h with empty scoreboard", ib.out_tag);
            end else begin
                exp_t e;
                e = sb_b.pop_front();
                chk("b_data", 32'(ib.out_data), e.data);
                chk("b_tag", 32'(ib.out_tag), 32'(e.tag));
                chk("b_illegal", 32'(ib.out_illegal), 32'(e.ill));
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that took the beat.
    task automatic send(input bit sel_b, input logic [15:0] dd, input logic [2:0] m,
                        input logic [4:0] t, input logic [31:0] ed, input logic eil);
        bit acc;
        exp_t e;
        e.data = ed;
        e.tag  = t;
        e.ill  = eil;
        acc = 1'b0;
        if (sel_b) begin
            ib.in_data = dd[7:0]; ib.in_mode = m; ib.in_tag = t; ib.in_valid = 1'b1;
        end else begin
            ia.in_data = dd; ia.in_mode = m; ia.in_tag = t; ia.in_valid = 1'b1;
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sel_b ? ib.in_ready : ia.in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no in_ready expected accept of tag %h", t);
        end else begin
            if (sel_b) sb_b.push_back(e);
            else       sb_a.push_back(e);
            if (first_acc < 0) first_acc = cyc;
        end
        @(posedge clk);
        #1;
        if (sel_b) ib.in_valid = 1'b0;
        else       ia.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_v;
        int run;
        ia.in_valid = 1'b0; ia.in_data = '0; ia.in_mode = '0; ia.in_tag = '0; ia.out_ready = 1'b1;
        ib.in_valid = 1'b0; ib.in_data = '0; ib.in_mode = '0; ib.in_tag = '0; ib.out_ready = 1'b1;

        #2 reset_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(ia.out_valid), 32'd0);
        chk("rst_in_ready", 32'(ia.in_ready), 32'd1);
        chk("rst_out_data", ia.out_data, 32'd0);
        chk("rst_out_tag", 32'(ia.out_tag), 32'd0);
        chk("rst_out_illegal", 32'(ia.out_illegal), 32'd0);
        chk("rst_err_sticky", 32'(ia.err_sticky), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        idle(1);

        // mode sweep
        send(0, 16'h8F81, 3'b000, 5'd0, 32'h00008F81, 1'b0);
        send(0, 16'h8F81, 3'b001, 5'd1, 32'hFFFF8F81, 1'b0);
        send(0, 16'h8F81, 3'b010, 5'd2, 32'h8F810000, 1'b0);
        send(0, 16'h8F81, 3'b011, 5'd3, 32'hFFFE3E04, 1'b0);
        send(0, 16'h8F81, 3'b100, 5'd4, 32'hFFFFFF81, 1'b0);
        send(0, 16'h8F81, 3'b101, 5'd5, 32'h00000081, 1'b0);
        send(0, 16'h8F81, 3'b110, 5'd6, 32'hFFFFFF81, 1'b0);
        idle(3);

        // illegal mode and sticky error
        send(0, 16'h1234, 3'b111, 5'd7, 32'h0, 1'b1);
        chk("sticky_set", 32'(ia.err_sticky), 32'd1);
        send(0, 16'h0001, 3'b000, 5'd8, 32'h1, 1'b0);
        chk("sticky_hold", 32'(ia.err_sticky), 32'd1);
        idle(3);

        // backpressure
        ia.out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 4; i++)
                    send(0, 16'(i * 16'h1111), 3'b000, 5'(i), 32'(i * 16'h1111), 1'b0);
            end
            begin
                repeat (4) @(negedge clk);
                chk("bp_in_ready_low", 32'(ia.in_ready), 32'd0);
                chk("bp_hold_data", ia.out_data, 32'h00001111);
                chk("bp_hold_tag", 32'(ia.out_tag), 32'd1);
                @(posedge clk);
                #1 ia.out_ready = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("bp_drain_valid", 32'(ia.out_valid), 32'd1);
                end
            end
        join
        idle(3);
        chk("bp_drained", 32'(sb_a.size()), 32'd0);

        // throughput
        first_acc = -1;
        first_v = -1;
        run = 0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(0, 16'(i * 3 + 1), 3'b000, 5'(i + 8), 32'(i * 3 + 1), 1'b0);
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    @(negedge clk);
                    if (ia.out_valid) begin
                        if (first_v < 0) first_v = cyc;
                        run++;
                    end else if (first_v >= 0) begin
                        break;
                    end
                end
            end
        join
        chk("tp_run_len", 32'(run), 32'd8);
        chk("tp_latency", 32'(first_v), 32'(first_acc + 1));
        idle(2);

        // reset with OUT and SKID both full
        ia.out_ready = 1'b0;
        send(0, 16'h00AA, 3'b111, 5'd20, 32'h0, 1'b1);
        send(0, 16'h00BB, 3'b000, 5'd21, 32'hBB, 1'b0);
        chk("mf_full_valid", 32'(ia.out_valid), 32'd1);
        chk("mf_full_in_ready", 32'(ia.in_ready), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("mf_out_valid", 32'(ia.out_valid), 32'd0);
        chk("mf_err_sticky", 32'(ia.err_sticky), 32'd0);
        chk("mf_in_ready", 32'(ia.in_ready), 32'd1);
        chk("mf_out_data", ia.out_data, 32'd0);
        sb_a.delete();
        @(negedge clk);
        reset_n = 1'b1;
        ia.out_ready = 1'b1;
        idle(1);
        send(0, 16'h0080, 3'b001, 5'd3, 32'h00000080, 1'b0);
        idle(3);

        // narrow variant
        send(1, 16'h00F0, 3'b001, 5'd1, 32'h0000FFF0, 1'b0);
        send(1, 16'h00F0, 3'b010, 5'd2, 32'h0000F000, 1'b0);
        send(1, 16'h0040, 3'b011, 5'd3, 32'h00000100, 1'b0);

        for (int k = 0; k < 50; k++) begin
            if (sb_a.size() == 0 && sb_b.size() == 0) break;
            @(negedge clk);
        end
        chk("sb_a_empty", 32'(sb_a.size()), 32'd0);
        chk("sb_b_empty", 32'(sb_b.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
